// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: turns reset / LED / typematic requests into command
// bytes, handles ACK, resend and BAT responses, and forwards every other received byte.
module ps2_cmd_sequencer #(
    parameter int RESP_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT  = 50_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       req_reset,
    input  logic       req_leds,
    input  logic [2:0] led_state,
    input  logic       req_rate,
    input  logic [7:0] rate_byte,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] scan_data,
    output logic       scan_valid,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] fail_code
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_SENT, S_WAIT_ACK, S_WAIT_BAT} state_t;
    typedef enum logic [1:0] {K_RESET, K_LEDS, K_RATE} kind_t;

    localparam logic [25:0] RESP_LIMIT = 26'(RESP_TIMEOUT - 1);
    localparam logic [25:0] BAT_LIMIT  = 26'(BAT_TIMEOUT - 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic          second_q, second_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic [25:0]   timer_q, timer_d;
    logic          pend_reset_q, pend_reset_d;
    logic          pend_leds_q, pend_leds_d;
    logic          pend_rate_q, pend_rate_d;
    logic [2:0]    led_q, led_d;
    logic [7:0]    rate_q, rate_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [1:0]    fail_code_q, fail_code_d;
    logic [7:0]    scan_data_q, scan_data_d;
    logic          scan_valid_q, scan_valid_d;
    logic          clr_reset, clr_leds, clr_rate;
    logic          rx_fa, rx_fe, rx_aa, rx_fc, consumed;

    assign rx_fa     = received_data_en && (received_data == 8'hFA);
    assign rx_fe     = received_data_en && (received_data == 8'hFE);
    assign rx_aa     = received_data_en && (received_data == 8'hAA);
    assign rx_fc     = received_data_en && (received_data == 8'hFC);
    assign retry_inc = retry_q + RW'(1);

    // Only protocol responses in the state expecting them are swallowed.
    assign consumed = ((state_q == S_WAIT_ACK) && (rx_fa || rx_fe)) ||
                      ((state_q == S_WAIT_BAT) && (rx_aa || rx_fc));

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        second_d    = second_q;
        data_d      = data_q;
        cmd_d       = cmd_q;
        retry_d     = retry_q;
        fail_code_d = fail_code_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        clr_reset   = 1'b0;
        clr_leds    = 1'b0;
        clr_rate    = 1'b0;

        case (state_q)
            S_IDLE: begin
                second_d = 1'b0;
                retry_d  = '0;
                if (pend_reset_q) begin
                    kind_d    = K_RESET;
                    cmd_d     = 8'hFF;
                    clr_reset = 1'b1;
                    state_d   = S_SEND;
                end else if (pend_leds_q) begin
                    kind_d   = K_LEDS;
                    cmd_d    = 8'hED;
                    data_d   = {5'b0, led_q};
                    clr_leds = 1'b1;
                    state_d  = S_SEND;
                end else if (pend_rate_q) begin
                    kind_d   = K_RATE;
                    cmd_d    = 8'hF3;
                    data_d   = rate_q;
                    clr_rate = 1'b1;
                    state_d  = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT_SENT;
            S_WAIT_SENT: begin
                if (command_was_sent) begin
                    state_d = S_WAIT_ACK;
                end else if (error_communication_timed_out) begin
                    fail_d      = 1'b1;
                    fail_code_d = 2'd3;
                    retry_d     = '0;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_ACK: begin
                if (rx_fa) begin
                    if (kind_q == K_RESET) begin
                        state_d = S_WAIT_BAT;
                    end else if (!second_q) begin
                        cmd_d    = data_q;
                        second_d = 1'b1;
                        retry_d  = '0;
                        state_d  = S_SEND;
                    end else begin
                        done_d  = 1'b1;
                        retry_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (rx_fe) begin
                    if (retry_inc == RETRY_LIMIT) begin
                        fail_d      = 1'b1;
                        fail_code_d = 2'd1;
                        retry_d     = '0;
                        state_d     = S_IDLE;
                    end else begin
                        retry_d = retry_inc;
                        state_d = S_SEND;
                    end
                end else if (!received_data_en && timer_q == RESP_LIMIT) begin
                    fail_d      = 1'b1;
                    fail_code_d = 2'd0;
                    retry_d     = '0;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_BAT: begin
                if (rx_aa) begin
                    done_d  = 1'b1;
                    retry_d = '0;
                    state_d = S_IDLE;
                end else if (rx_fc) begin
                    fail_d      = 1'b1;
                    fail_code_d = 2'd2;
                    retry_d     = '0;
                    state_d     = S_IDLE;
                end else if (!received_data_en && timer_q == BAT_LIMIT) begin
                    fail_d      = 1'b1;
                    fail_code_d = 2'd0;
                    retry_d     = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter restarts on every entry into a waiting state and saturates.
        if ((state_d == S_WAIT_ACK || state_d == S_WAIT_BAT) && state_d == state_q) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + 26'd1;
        end else begin
            timer_d = '0;
        end

        pend_reset_d = (pend_reset_q & ~clr_reset) | req_reset;
        pend_leds_d  = (pend_leds_q & ~clr_leds) | req_leds;
        pend_rate_d  = (pend_rate_q & ~clr_rate) | req_rate;
        led_d        = req_leds ? led_state : led_q;
        rate_d       = req_rate ? rate_byte : rate_q;

        scan_valid_d = received_data_en && !consumed;
        scan_data_d  = scan_valid_d ? received_data : scan_data_q;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            kind_q       <= K_RESET;
            second_q     <= 1'b0;
            data_q       <= '0;
            cmd_q        <= '0;
            retry_q      <= '0;
            timer_q      <= '0;
            pend_reset_q <= 1'b0;
            pend_leds_q  <= 1'b0;
            pend_rate_q  <= 1'b0;
            led_q        <= '0;
            rate_q       <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= '0;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            second_q     <= second_d;
            data_q       <= data_d;
            cmd_q        <= cmd_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            pend_reset_q <= pend_reset_d;
            pend_leds_q  <= pend_leds_d;
            pend_rate_q  <= pend_rate_d;
            led_q        <= led_d;
            rate_q       <= rate_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    assign the_command  = cmd_q;
    assign send_command = (state_q == S_SEND);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign fail         = fail_q;
    assign fail_code    = fail_code_q;
    assign scan_data    = scan_data_q;
    assign scan_valid   = scan_valid_q;
endmodule
